pc_stack_unit: RTL and testbench

- Parametrised next-generation program-counter unit for the RISC core fetch stage.
- Selects next PC from: interrupt vector, return-stack pop, branch/call target, stall, or sequential increment.
- Sequential increment is 1 byte, or 2 bytes for two-byte opcodes.
- Adds a hardware return-address stack (LIFO) for CALL/RET and interrupt entry/return (RTI), with sticky overflow/underflow error flags.

---
 rtl/pc_stack_unit.sv | 158 +++++++++++++++
 tb/tb_pc_stack_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack_unit
// Purpose  : Fetch-stage next-PC selection with a hardware return-address
//            stack for CALL/RET and interrupt entry/RTI, with sticky
//            overflow/underflow flags.
// Options  : PC_STACK_INT_MASK_EN - block nested interrupts while one is
//            in service (until the matching RTI).
// Revision : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
  parameter int                ADDR_W       = 8,
  parameter int                STACK_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [3:0]        TWO_BYTE_OP  = 4'hC
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pc_stall,
  input  logic                             interrupt_trigger,
  input  logic [ADDR_W-1:0]                interrupt_vector,
  input  logic                             pc_branch_taken,
  input  logic                             call_en,
  input  logic [ADDR_W-1:0]                call_ret_addr,
  input  logic [ADDR_W-1:0]                branch_target,
  input  logic                             ret_en,
  input  logic                             rti_en,
  input  logic [7:0]                       instr_fetched,
  input  logic                             err_clr,
  output logic [ADDR_W-1:0]                pc_current,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             stack_overflow,
  output logic                             stack_underflow
);

  localparam int                 c_cnt_w = $clog2(STACK_DEPTH + 1);
  localparam int                 c_idx_w = $clog2(STACK_DEPTH);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(STACK_DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
  logic [ADDR_W-1:0]  r_pc;
  logic [c_cnt_w-1:0] r_count;
  logic               r_ovf;
  logic               r_unf;

  logic               w_int_ok;
  logic               w_take_int;
  logic               w_pop;
  logic               w_call;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [c_cnt_w-1:0] w_cnt_m1;
  logic [c_idx_w-1:0] w_wr_idx;
  logic [c_idx_w-1:0] w_rd_idx;
  logic [ADDR_W-1:0]  w_push_data;
  logic [ADDR_W-1:0]  w_top;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_unused;

`ifdef PC_STACK_INT_MASK_EN
  logic r_in_service;
  assign w_int_ok = ~r_in_service;
`else
  assign w_int_ok = 1'b1;
`endif

  // Only the opcode nibble affects instruction length.
  assign w_unused = ^instr_fetched[3:0];

  // Priority arbitration: a winning request suppresses every push/pop below it.
  assign w_take_int  = interrupt_trigger & w_int_ok;
  assign w_pop       = ~w_take_int & (ret_en | rti_en);
  assign w_call      = ~w_take_int & ~w_pop & call_en;
  assign w_push      = w_take_int | w_call;
  assign w_push_data = w_take_int ? r_pc : call_ret_addr;

  assign w_full   = (r_count == c_full);
  assign w_empty  = (r_count == '0);
  assign w_cnt_m1 = r_count - c_one;
  assign w_wr_idx = r_count[c_idx_w-1:0];
  assign w_rd_idx = w_cnt_m1[c_idx_w-1:0];
  assign w_top    = r_stack[w_rd_idx];

  assign w_pc_inc = r_pc + ((instr_fetched[7:4] == TWO_BYTE_OP) ? ADDR_W'(2) : ADDR_W'(1));

  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_take_int) begin
      w_pc_next = interrupt_vector;
    end else if (w_pop) begin
      w_pc_next = w_empty ? RESET_VECTOR : w_top;
    end else if (w_call || pc_branch_taken) begin
      w_pc_next = branch_target;
    end else if (pc_stall) begin
      w_pc_next = r_pc;
    end
  end

  // Stack storage is not reset; occupancy is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (rst_n && w_push && !w_full) begin
      r_stack[w_wr_idx] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc <= w_pc_next;

      if (err_clr) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end

      // Error setting follows the clear so a coincident new error wins.
      if (w_push) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_count <= r_count + c_one;
        end
      end else if (w_pop) begin
        if (w_empty) begin
          r_unf <= 1'b1;
        end else begin
          r_count <= w_cnt_m1;
        end
      end
    end
  end

`ifdef PC_STACK_INT_MASK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_service <= 1'b0;
    end else if (w_take_int) begin
      r_in_service <= 1'b1;
    end else if (w_pop && rti_en) begin
      r_in_service <= 1'b0;
    end
  end
`endif

  assign pc_current      = r_pc;
  assign stack_count     = r_count;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// Directed self-checking bench for pc_stack_unit (default parameters).
// Each step compares the packed tuple {pc, count, overflow, underflow}.
module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pc_stall;
  logic       interrupt_trigger;
  logic [7:0] interrupt_vector;
  logic       pc_branch_taken;
  logic       call_en;
  logic [7:0] call_ret_addr;
  logic [7:0] branch_target;
  logic       ret_en;
  logic       rti_en;
  logic [7:0] instr_fetched;
  logic       err_clr;
  logic [7:0] pc_current;
  logic [2:0] stack_count;
  logic       stack_overflow;
  logic       stack_underflow;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp;
  wire  [12:0] obs = {pc_current, stack_count, stack_overflow, stack_underflow};

  always #5 clk = ~clk;

  pc_stack_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_stall          (pc_stall),
    .interrupt_trigger (interrupt_trigger),
    .interrupt_vector  (interrupt_vector),
    .pc_branch_taken   (pc_branch_taken),
    .call_en           (call_en),
    .call_ret_addr     (call_ret_addr),
    .branch_target     (branch_target),
    .ret_en            (ret_en),
    .rti_en            (rti_en),
    .instr_fetched     (instr_fetched),
    .err_clr           (err_clr),
    .pc_current        (pc_current),
    .stack_count       (stack_count),
    .stack_overflow    (stack_overflow),
    .stack_underflow   (stack_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_stall          = 1'b0;
    interrupt_trigger = 1'b0;
    interrupt_vector  = 8'h00;
    pc_branch_taken   = 1'b0;
    call_en           = 1'b0;
    call_ret_addr     = 8'h00;
    branch_target     = 8'h00;
    ret_en            = 1'b0;
    rti_en            = 1'b0;
    err_clr           = 1'b0;
    instr_fetched     = 8'h10;
  endtask

  task automatic jump_to(input logic [7:0] addr);
    idle();
    pc_branch_taken = 1'b1;
    branch_target   = addr;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    exp = {8'h00, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    rst_n = 1'b1;
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = {8'(i), 3'd0, 1'b0, 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL inc1_%0d: pc/cnt/ovf/unf=%h required %h", i, obs, exp); end
    end
    instr_fetched = 8'hC0;
    tick();
    exp = {8'h05, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL inc2: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    jump_to(8'hFF);
    exp = {8'hFF, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL branch_ff: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    instr_fetched = 8'hC0;
    tick();
    exp = {8'h01, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL wrap2: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    pc_stall = 1'b1;
    tick();
    checks++; if (obs !== exp) begin errors++; $display("FAIL stall: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
  endtask

  task automatic test_call_ret();
    jump_to(8'h20);
    call_en       = 1'b1;
    branch_target = 8'h80;
    call_ret_addr = 8'h22;
    tick();
    exp = {8'h80, 3'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL call: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
    ret_en = 1'b1;
    tick();
    exp = {8'h22, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL ret: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
  endtask

  task automatic test_int_priority();
    jump_to(8'h40);
    interrupt_trigger = 1'b1;
    interrupt_vector  = 8'hF0;
    ret_en            = 1'b1;
    pc_stall          = 1'b1;
    tick();
    exp = {8'hF0, 3'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL int_prio: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
    rti_en = 1'b1;
    tick();
    exp = {8'h40, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL rti: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] e_pc;
    logic [2:0] e_cnt;
    for (int i = 0; i < 5; i++) begin
      idle();
      call_en       = 1'b1;
      branch_target = 8'h81 + 8'(i);
      call_ret_addr = 8'h11 + 8'(i);
      tick();
      e_pc  = 8'h81 + 8'(i);
      e_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
      exp   = {e_pc, e_cnt, (i == 4), 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL push_%0d: pc/cnt/ovf/unf=%h required %h", i, obs, exp); end
    end
    for (int j = 0; j < 4; j++) begin
      idle();
      ret_en = 1'b1;
      tick();
      e_pc  = 8'h14 - 8'(j);
      e_cnt = 3'(3 - j);
      exp   = {e_pc, e_cnt, 1'b1, 1'b0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL pop_%0d: pc/cnt/ovf/unf=%h required %h", j, obs, exp); end
    end
    tick();
    exp = {8'h00, 3'd0, 1'b1, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL underflow: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    err_clr = 1'b1;
    tick();
    exp = {8'h00, 3'd0, 1'b0, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL set_wins: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
    err_clr  = 1'b1;
    pc_stall = 1'b1;
    tick();
    exp = {8'h00, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL err_clr: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    ret_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      call_en       = 1'b1;
      branch_target = 8'h90 + 8'(i);
      call_ret_addr = 8'hA0 + 8'(i);
      tick();
    end
    exp = {8'h92, 3'd3, 1'b0, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL pre_reset: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
    rst_n = 1'b0;
    tick();
    exp = {8'h00, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL mid_reset: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    rst_n  = 1'b1;
    ret_en = 1'b1;
    tick();
    exp = {8'h00, 3'd0, 1'b0, 1'b1};
    checks++; if (obs !== exp) begin errors++; $display("FAIL post_reset_pop: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
    err_clr  = 1'b1;
    pc_stall = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_nested_int();
    jump_to(8'h30);
    interrupt_trigger = 1'b1;
    interrupt_vector  = 8'hF0;
    tick();
    exp = {8'hF0, 3'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL int1: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    interrupt_vector = 8'hE0;
    pc_stall         = 1'b1;
    tick();
`ifdef PC_STACK_INT_MASK_EN
    exp = {8'hF0, 3'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL int2_masked: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
    rti_en = 1'b1;
    tick();
    exp = {8'h30, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL rti1: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
    interrupt_trigger = 1'b1;
    interrupt_vector  = 8'hE0;
    tick();
    exp = {8'hE0, 3'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL int_after_rti: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
    rti_en = 1'b1;
    tick();
    exp = {8'h30, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL rti2: pc/cnt/ovf/unf=%h required %h", obs, exp); end
`else
    exp = {8'hE0, 3'd2, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL int2_nested: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    idle();
    rti_en = 1'b1;
    tick();
    exp = {8'hF0, 3'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL rti_inner: pc/cnt/ovf/unf=%h required %h", obs, exp); end
    tick();
    exp = {8'h30, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL rti_outer: pc/cnt/ovf/unf=%h required %h", obs, exp); end
`endif
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_increment();
    test_call_ret();
    test_int_priority();
    test_overflow_underflow();
    test_reset_mid();
    test_nested_int();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
